// File: rtl/rle_encoder_gen.sv
// ---------------------------------------------------------------------------
// rle_encoder_gen
//
// Parametrised run-length encoder. A frame of SYM_W-bit symbols is read from
// a single-port SRAM, collapsed into {value,count} pairs and packed back into
// the same SRAM. Runs saturate at 2^CNT_W-1 and then split into a new pair.
// Inside each PAIR_W slice of a packed word the symbol value occupies the low
// SYM_W bits and the count the bits above it. Slices fill from bit 0 upward.
//
// Ports
//   clk           clock (also clocks the SRAM)
//   nreset        synchronous, active-low reset
//   start         one-cycle pulse; starts (or restarts) a frame
//   message_addr  byte address of the plaintext (word aligned)
//   message_size  plaintext length in bytes (multiple of SYM_W/8)
//   rle_addr      byte address of the encoded output (word aligned)
//   rle_size      bytes of encoded pairs emitted for the current frame
//   busy          frame in progress
//   done          frame complete; held until the next start or reset
//   mem_addr      SRAM byte address
//   mem_we        SRAM write enable (1 = write, 0 = read)
//   mem_wdata     SRAM write data
//   mem_rdata     SRAM read data, valid one cycle after a read address
// ---------------------------------------------------------------------------
module rle_encoder_gen #(
  parameter int SYM_W  = 8,
  parameter int CNT_W  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       message_size,
  input  logic [31:0]       rle_addr,
  output logic [31:0]       rle_size,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PAIR_W         = SYM_W + CNT_W;
  localparam int SYMS_PER_WORD  = DATA_W / SYM_W;
  localparam int PAIRS_PER_WORD = DATA_W / PAIR_W;
  localparam int SYM_BYTES      = SYM_W / 8;
  localparam int WORD_BYTES     = DATA_W / 8;
  localparam int PAIR_BYTES     = PAIR_W / 8;
  localparam int WCNT_W         = $clog2(SYMS_PER_WORD + 1);
  localparam int PCNT_W         = $clog2(PAIRS_PER_WORD + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] WORD_INC = ADDR_W'(WORD_BYTES);
  localparam logic [31:0]       PAIR_INC = 32'(PAIR_BYTES);
  localparam logic [31:0]       SYM_DIV  = 32'(SYM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_LOAD = 3'd2,
    S_SCAN = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t              state_r;
  logic                go_r;         // IDLE holds a freshly latched frame
  logic                fin_r;        // the pending write is the last of the frame
  logic [ADDR_W-1:0]   msg_base_r;
  logic [ADDR_W-1:0]   rle_base_r;
  logic [ADDR_W-1:0]   rd_off_r;
  logic [ADDR_W-1:0]   wr_off_r;
  logic [31:0]         sym_left_r;   // symbols of the frame not yet scanned
  logic [WCNT_W-1:0]   word_left_r;  // symbols left in the shift register
  logic [DATA_W-1:0]   shift_r;
  logic                run_open_r;
  logic [SYM_W-1:0]    run_val_r;
  logic [CNT_W-1:0]    run_cnt_r;
  logic [DATA_W-1:0]   pack_r;
  logic [PCNT_W-1:0]   pack_cnt_r;
  logic [31:0]         rle_size_r;
  logic                busy_r;
  logic                done_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic                mem_we_r;
  logic [DATA_W-1:0]   mem_wdata_r;

  logic [SYM_W-1:0]    cur_sym_s;
  logic [PAIR_W-1:0]   pair_s;
  logic                emit_s;
  logic                pack_full_s;
  logic [DATA_W-1:0]   pack_next_s;

  // Upper address bits beyond the SRAM address space are intentionally dropped.
  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^{message_addr[31:ADDR_W], rle_addr[31:ADDR_W]};

  // Decide whether the head symbol (or the end-of-frame flush) closes the
  // open run, and form the pack word that results from appending that pair.
  always_comb begin
    cur_sym_s   = shift_r[SYM_W-1:0];
    pair_s      = {run_cnt_r, run_val_r};
    emit_s      = 1'b0;
    pack_next_s = pack_r;
    if (sym_left_r == 32'd0) begin
      // No symbols left: the flush cycle always closes the open run.
      emit_s = run_open_r;
    end else if (run_open_r && ((cur_sym_s != run_val_r) || (run_cnt_r == CNT_MAX))) begin
      emit_s = 1'b1;
    end else begin
      emit_s = 1'b0;
    end
    for (int i = 0; i < PAIRS_PER_WORD; i++) begin
      if (pack_cnt_r == PCNT_W'(i)) begin
        pack_next_s[i*PAIR_W +: PAIR_W] = pair_s;
      end else begin
        pack_next_s[i*PAIR_W +: PAIR_W] = pack_r[i*PAIR_W +: PAIR_W];
      end
    end
    pack_full_s = emit_s && (pack_cnt_r == PCNT_W'(PAIRS_PER_WORD - 1));
  end

  // Frame sequencer: state, offsets, run and pack registers, and all outputs.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_r     <= S_IDLE;
      go_r        <= 1'b0;
      fin_r       <= 1'b0;
      msg_base_r  <= {ADDR_W{1'b0}};
      rle_base_r  <= {ADDR_W{1'b0}};
      rd_off_r    <= {ADDR_W{1'b0}};
      wr_off_r    <= {ADDR_W{1'b0}};
      sym_left_r  <= 32'd0;
      word_left_r <= {WCNT_W{1'b0}};
      shift_r     <= {DATA_W{1'b0}};
      run_open_r  <= 1'b0;
      run_val_r   <= {SYM_W{1'b0}};
      run_cnt_r   <= {CNT_W{1'b0}};
      pack_r      <= {DATA_W{1'b0}};
      pack_cnt_r  <= {PCNT_W{1'b0}};
      rle_size_r  <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_we_r    <= 1'b0;
      mem_wdata_r <= {DATA_W{1'b0}};
    end else if (start) begin
      // start overrides any state: latch the new frame and begin afresh.
      state_r     <= S_IDLE;
      go_r        <= 1'b1;
      fin_r       <= 1'b0;
      msg_base_r  <= message_addr[ADDR_W-1:0];
      rle_base_r  <= rle_addr[ADDR_W-1:0];
      rd_off_r    <= {ADDR_W{1'b0}};
      wr_off_r    <= {ADDR_W{1'b0}};
      sym_left_r  <= message_size / SYM_DIV;
      word_left_r <= {WCNT_W{1'b0}};
      shift_r     <= {DATA_W{1'b0}};
      run_open_r  <= 1'b0;
      run_val_r   <= {SYM_W{1'b0}};
      run_cnt_r   <= {CNT_W{1'b0}};
      pack_r      <= {DATA_W{1'b0}};
      pack_cnt_r  <= {PCNT_W{1'b0}};
      rle_size_r  <= 32'd0;
      busy_r      <= 1'b1;
      done_r      <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (go_r) begin
            go_r <= 1'b0;
            if (sym_left_r == 32'd0) begin
              state_r <= S_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              mem_addr_r <= msg_base_r + rd_off_r;
              rd_off_r   <= rd_off_r + WORD_INC;
              state_r    <= S_RD;
            end
          end
        end

        S_RD: begin
          state_r <= S_LOAD;
        end

        S_LOAD: begin
          shift_r     <= mem_rdata;
          word_left_r <= WCNT_W'(SYMS_PER_WORD);
          state_r     <= S_SCAN;
        end

        S_SCAN: begin
          if (sym_left_r == 32'd0) begin
            // Flush: close the open run and write out whatever is packed.
            run_open_r  <= 1'b0;
            rle_size_r  <= rle_size_r + PAIR_INC;
            mem_we_r    <= 1'b1;
            mem_addr_r  <= rle_base_r + wr_off_r;
            wr_off_r    <= wr_off_r + WORD_INC;
            mem_wdata_r <= pack_next_s;
            pack_r      <= {DATA_W{1'b0}};
            pack_cnt_r  <= {PCNT_W{1'b0}};
            fin_r       <= 1'b1;
            state_r     <= S_WR;
          end else begin
            // Consume the head symbol; it either extends the run or opens one.
            shift_r     <= shift_r >> SYM_W;
            word_left_r <= word_left_r - WCNT_W'(1);
            sym_left_r  <= sym_left_r - 32'd1;
            run_open_r  <= 1'b1;
            run_val_r   <= cur_sym_s;
            if (emit_s || !run_open_r) begin
              run_cnt_r <= CNT_ONE;
            end else begin
              run_cnt_r <= run_cnt_r + CNT_ONE;
            end
            if (emit_s) begin
              rle_size_r <= rle_size_r + PAIR_INC;
            end
            if (pack_full_s) begin
              mem_we_r    <= 1'b1;
              mem_addr_r  <= rle_base_r + wr_off_r;
              wr_off_r    <= wr_off_r + WORD_INC;
              mem_wdata_r <= pack_next_s;
              pack_r      <= {DATA_W{1'b0}};
              pack_cnt_r  <= {PCNT_W{1'b0}};
              state_r     <= S_WR;
            end else begin
              if (emit_s) begin
                pack_r     <= pack_next_s;
                pack_cnt_r <= pack_cnt_r + PCNT_W'(1);
              end
              if (sym_left_r == 32'd1) begin
                state_r <= S_SCAN;          // next cycle is the flush
              end else if (word_left_r == WCNT_W'(1)) begin
                mem_addr_r <= msg_base_r + rd_off_r;
                rd_off_r   <= rd_off_r + WORD_INC;
                state_r    <= S_RD;
              end else begin
                state_r <= S_SCAN;
              end
            end
          end
        end

        S_WR: begin
          mem_we_r    <= 1'b0;
          mem_wdata_r <= {DATA_W{1'b0}};
          if (fin_r) begin
            fin_r   <= 1'b0;
            state_r <= S_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else if (sym_left_r == 32'd0) begin
            state_r <= S_SCAN;
          end else if (word_left_r == {WCNT_W{1'b0}}) begin
            mem_addr_r <= msg_base_r + rd_off_r;
            rd_off_r   <= rd_off_r + WORD_INC;
            state_r    <= S_RD;
          end else begin
            state_r <= S_SCAN;
          end
        end

        S_DONE: begin
          state_r <= S_DONE;
        end

        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign rle_size  = rle_size_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign mem_addr  = mem_addr_r;
  assign mem_we    = mem_we_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_rle_encoder_gen.sv
// ---------------------------------------------------------------------------
// tb_rle_encoder_gen
//
// Bench for rle_encoder_gen. Instance a uses the default 8/8/32/16 sizing,
// instance b uses 16-bit symbols and counts. Each instance has its own
// read-only message memory; writes are captured into queues and compared
// with expected words. Directed vectors come from a table, multi-cycle corner
// cases are hand sequenced, and random frames are checked against a run-list
// model that works on whole byte lists.
// ---------------------------------------------------------------------------
module tb_rle_encoder_gen;

  typedef logic [31:0] word_q_t[$];
  typedef logic [7:0]  byte_q_t[$];

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] size;
    int          nwr;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] esize;
  } vec_t;

  logic        clk = 1'b0;
  logic        nreset;

  logic        a_start;
  logic [31:0] a_message_addr, a_message_size, a_rle_addr, a_rle_size;
  logic        a_busy, a_done, a_we;
  logic [15:0] a_addr;
  logic [31:0] a_wdata, a_rdata;

  logic        b_start;
  logic [31:0] b_message_addr, b_message_size, b_rle_addr, b_rle_size;
  logic        b_busy, b_done, b_we;
  logic [15:0] b_addr;
  logic [31:0] b_wdata, b_rdata;

  logic [31:0] mem_a [0:16383];
  logic [31:0] mem_b [0:16383];
  logic [15:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [15:0] wba_q[$];
  logic [31:0] wbd_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rle_encoder_gen dut_a (
    .clk(clk), .nreset(nreset), .start(a_start),
    .message_addr(a_message_addr), .message_size(a_message_size),
    .rle_addr(a_rle_addr), .rle_size(a_rle_size),
    .busy(a_busy), .done(a_done),
    .mem_addr(a_addr), .mem_we(a_we), .mem_wdata(a_wdata), .mem_rdata(a_rdata)
  );

  rle_encoder_gen #(.SYM_W(16), .CNT_W(16), .DATA_W(32), .ADDR_W(16)) dut_b (
    .clk(clk), .nreset(nreset), .start(b_start),
    .message_addr(b_message_addr), .message_size(b_message_size),
    .rle_addr(b_rle_addr), .rle_size(b_rle_size),
    .busy(b_busy), .done(b_done),
    .mem_addr(b_addr), .mem_we(b_we), .mem_wdata(b_wdata), .mem_rdata(b_rdata)
  );

  // SRAM read ports and write capture.
  always @(posedge clk) begin
    a_rdata <= mem_a[a_addr[15:2]];
    b_rdata <= mem_b[b_addr[15:2]];
    if (a_we) begin
      wa_q.push_back(a_addr);
      wd_q.push_back(a_wdata);
    end
    if (b_we) begin
      wba_q.push_back(b_addr);
      wbd_q.push_back(b_wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic start_a(input logic [31:0] maddr, input logic [31:0] msize,
                         input logic [31:0] raddr);
    @(negedge clk);
    wa_q.delete();
    wd_q.delete();
    a_message_addr = maddr;
    a_message_size = msize;
    a_rle_addr     = raddr;
    a_start        = 1'b1;
    @(negedge clk);
    a_start        = 1'b0;
  endtask

  task automatic wait_done_a(output int cyc);
    cyc = 1;
    while (!a_done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Run-list model: runs of equal bytes split at 255, pairs packed two per word.
  task automatic model_a(input byte_q_t msg, output word_q_t words, output logic [31:0] nbytes);
    int vals[$];
    int cnts[$];
    int last;
    logic [31:0] w;
    words = {};
    foreach (msg[i]) begin
      last = cnts.size() - 1;
      if (last >= 0 && vals[last] == int'(msg[i]) && cnts[last] < 255) begin
        cnts[last] = cnts[last] + 1;
      end else begin
        vals.push_back(int'(msg[i]));
        cnts.push_back(1);
      end
    end
    nbytes = 32'(2 * vals.size());
    for (int p = 0; p < vals.size(); p += 2) begin
      w = 32'((cnts[p] << 8) | vals[p]);
      if (p + 1 < vals.size()) begin
        w = w | (32'((cnts[p+1] << 8) | vals[p+1]) << 16);
      end
      words.push_back(w);
    end
  endtask

  initial begin
    vec_t        vecs[6];
    int          cyc;
    int          hits;
    byte_q_t     msg;
    word_q_t     exp_w;
    logic [31:0] exp_sz;
    logic [31:0] word;
    logic [31:0] raddr;
    logic [7:0]  b;
    int          len;

    vecs[0] = '{32'h41414141, 32'h42424141, 32'd8, 1, 32'h02420641, 32'h0, 32'd4};
    vecs[1] = '{32'h22221111, 32'hDEAD3333, 32'd6, 2, 32'h02220211, 32'h00000233, 32'd6};
    vecs[2] = '{32'h44332211, 32'h0,        32'd4, 2, 32'h01220111, 32'h01440133, 32'd8};
    vecs[3] = '{32'hAAAAAA7F, 32'h0,        32'd1, 1, 32'h0000017F, 32'h0, 32'd2};
    vecs[4] = '{32'h55555555, 32'h55555555, 32'd8, 1, 32'h00000855, 32'h0, 32'd2};
    vecs[5] = '{32'h66666666, 32'hCCBB9977, 32'd5, 1, 32'h01770466, 32'h0, 32'd4};

    nreset = 1'b0;
    a_start = 1'b0; a_message_addr = 32'd0; a_message_size = 32'd0; a_rle_addr = 32'd0;
    b_start = 1'b0; b_message_addr = 32'd0; b_message_size = 32'd0; b_rle_addr = 32'd0;
    repeat (3) @(negedge clk);
    check("reset rle_size", a_rle_size, 32'd0);
    check("reset busy",     {31'd0, a_busy}, 32'd0);
    check("reset done",     {31'd0, a_done}, 32'd0);
    check("reset mem_we",   {31'd0, a_we}, 32'd0);
    check("reset wdata",    a_wdata, 32'd0);
    check("reset b done",   {31'd0, b_done}, 32'd0);
    nreset = 1'b1;
    @(negedge clk);

    // Table-driven directed frames.
    for (int v = 0; v < 6; v++) begin
      mem_a[16'h0040] = vecs[v].w0;
      mem_a[16'h0041] = vecs[v].w1;
      start_a(32'h0100, vecs[v].size, 32'h0800);
      wait_done_a(cyc);
      check($sformatf("vec%0d done", v), {31'd0, a_done}, 32'd1);
      check($sformatf("vec%0d busy", v), {31'd0, a_busy}, 32'd0);
      check($sformatf("vec%0d rle_size", v), a_rle_size, vecs[v].esize);
      check($sformatf("vec%0d writes", v), 32'(wd_q.size()), 32'(vecs[v].nwr));
      if (wd_q.size() >= 1) begin
        check($sformatf("vec%0d addr0", v), {16'd0, wa_q[0]}, 32'h0800);
        check($sformatf("vec%0d data0", v), wd_q[0], vecs[v].e0);
      end
      if (vecs[v].nwr == 2 && wd_q.size() >= 2) begin
        check($sformatf("vec%0d addr1", v), {16'd0, wa_q[1]}, 32'h0804);
        check($sformatf("vec%0d data1", v), wd_q[1], vecs[v].e1);
      end
      if (v == 0) begin
        check("vec0 latency<=20", {31'd0, cyc <= 20}, 32'd1);
      end
    end

    // 300 bytes of 0x41: saturated run splits into FF + 2D.
    for (int i = 0; i < 75; i++) mem_a[16'h0400 + i] = 32'h41414141;
    start_a(32'h1000, 32'd300, 32'h3000);
    wait_done_a(cyc);
    check("sat done", {31'd0, a_done}, 32'd1);
    check("sat rle_size", a_rle_size, 32'd4);
    check("sat writes", 32'(wd_q.size()), 32'd1);
    if (wd_q.size() >= 1) begin
      check("sat addr", {16'd0, wa_q[0]}, 32'h3000);
      check("sat data", wd_q[0], 32'h2D41FF41);
    end

    // Zero-length frame started from DONE: done drops, then rises two cycles on.
    start_a(32'hA000, 32'd0, 32'hB000);
    check("zero cyc1 done", {31'd0, a_done}, 32'd0);
    check("zero cyc1 busy", {31'd0, a_busy}, 32'd1);
    @(negedge clk);
    check("zero cyc2 done", {31'd0, a_done}, 32'd1);
    check("zero cyc2 busy", {31'd0, a_busy}, 32'd0);
    check("zero rle_size", a_rle_size, 32'd0);
    repeat (3) @(negedge clk);
    check("zero writes", 32'(wd_q.size()), 32'd0);
    check("zero done held", {31'd0, a_done}, 32'd1);

    // Abort: restart mid-frame with new addresses.
    for (int i = 0; i < 16; i++) begin
      mem_a[16'h1000 + i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    end
    mem_a[16'h1800] = 32'h41414141;
    mem_a[16'h1801] = 32'h42424141;
    start_a(32'h4000, 32'd64, 32'h5000);
    repeat (20) @(negedge clk);
    check("abort old busy", {31'd0, a_busy}, 32'd1);
    check("abort old rle_size>0", {31'd0, a_rle_size != 32'd0}, 32'd1);
    start_a(32'h6000, 32'd8, 32'h7000);
    check("abort rle_size cleared", a_rle_size, 32'd0);
    check("abort busy", {31'd0, a_busy}, 32'd1);
    wait_done_a(cyc);
    check("abort done", {31'd0, a_done}, 32'd1);
    check("abort rle_size", a_rle_size, 32'd4);
    hits = 0;
    foreach (wa_q[k]) begin
      if (wa_q[k] >= 16'h7000 && wa_q[k] < 16'h7100) begin
        hits++;
        check("abort new addr", {16'd0, wa_q[k]}, 32'h7000);
        check("abort new data", wd_q[k], 32'h02420641);
      end
    end
    check("abort new writes", 32'(hits), 32'd1);

    // Random frames against the run-list model.
    for (int it = 0; it < 12; it++) begin
      len = $urandom_range(1, 40);
      msg = {};
      b = 8'h10;
      for (int i = 0; i < len; i++) begin
        if (i == 0 || $urandom_range(0, 1) == 0) b = 8'h10 + 8'($urandom_range(0, 2));
        msg.push_back(b);
      end
      for (int w = 0; w < (len + 3) / 4; w++) begin
        word = $urandom;
        for (int j = 0; j < 4; j++) begin
          if (4*w + j < len) word[8*j +: 8] = msg[4*w + j];
        end
        mem_a[16'h2000 + w] = word;
      end
      model_a(msg, exp_w, exp_sz);
      raddr = 32'h9000 + 32'(it * 256);
      start_a(32'h8000, 32'(len), raddr);
      wait_done_a(cyc);
      check($sformatf("rnd%0d done", it), {31'd0, a_done}, 32'd1);
      check($sformatf("rnd%0d rle_size", it), a_rle_size, exp_sz);
      check($sformatf("rnd%0d writes", it), 32'(wd_q.size()), 32'(exp_w.size()));
      for (int k = 0; k < exp_w.size() && k < wd_q.size(); k++) begin
        check($sformatf("rnd%0d addr%0d", it, k), {16'd0, wa_q[k]}, raddr + 32'(4*k));
        check($sformatf("rnd%0d data%0d", it, k), wd_q[k], exp_w[k]);
      end
    end

    // 16-bit symbols and counts: four 0xABCD give one full-word pair.
    mem_b[16'h0080] = 32'hABCDABCD;
    mem_b[16'h0081] = 32'hABCDABCD;
    @(negedge clk);
    b_message_addr = 32'h0200;
    b_message_size = 32'd8;
    b_rle_addr     = 32'h0400;
    b_start        = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    cyc = 1;
    while (!b_done && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("w16 done", {31'd0, b_done}, 32'd1);
    check("w16 rle_size", b_rle_size, 32'd4);
    check("w16 writes", 32'(wbd_q.size()), 32'd1);
    if (wbd_q.size() >= 1) begin
      check("w16 addr", {16'd0, wba_q[0]}, 32'h0400);
      check("w16 data", wbd_q[0], 32'h0004ABCD);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
